// File: rtl/cxu_pkg.sv
// Shared definitions for the cxu_bitbuf deflate bit-reader CXU:
// function identifiers, STATUS word bit positions and the
// reverse-within-n helper used by PEEKR.
package cxu_pkg;

    typedef enum logic [2:0] {
        F_CLEAR  = 3'd0,
        F_PUSH   = 3'd1,
        F_PEEK   = 3'd2,
        F_SKIP   = 3'd3,
        F_GET    = 3'd4,
        F_PEEKR  = 3'd5,
        F_STATUS = 3'd6,
        F_STATS  = 3'd7
    } func_e;

    localparam int unsigned ST_OVF_BIT    = 15;
    localparam int unsigned ST_UNF_BIT    = 14;
    localparam int unsigned ST_BADCTX_BIT = 13;
    localparam int unsigned ST_CNT_W      = 7;

    // Reverse the low n bits of v into Huffman code order; n=0 yields 0
    // because the shift amount reaches the full word width.
    function automatic logic [31:0] bitrev_n(input logic [31:0] v, input logic [4:0] n);
        logic [31:0] r;
        logic [5:0]  sh;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        sh = 6'd32 - {1'b0, n};
        return r >> sh;
    endfunction

endpackage

// File: rtl/cxu_bitbuf_ctx.sv
// One bit-reader context: LSB-first accumulator, bit count, sticky
// OVF/UNF/BADCTX flags and, with CXU_BITBUF_STATS_EN defined, a 32-bit
// consumed-bit counter. The response word is computed combinationally
// for the top-level response register.
module cxu_bitbuf_ctx import cxu_pkg::*; #(
    parameter int unsigned ACC_W = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_en,
    input  logic        bad_set,
    input  func_e       func,
    input  logic [31:0] data,
    input  logic [4:0]  n,
    output logic [31:0] rsp
);

    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] bitcnt, bitcnt_nx;
    logic             ovf, ovf_nx, unf, unf_nx, badctx, bad_nx;
    logic [CNT_W-1:0] n_ext;
    logic             short_n, push_ok;
    logic [31:0]      mask, field;
`ifdef CXU_BITBUF_STATS_EN
    logic [31:0]      cons_cnt, cnt_nx;
`endif

    assign n_ext   = CNT_W'(n);
    assign short_n = n_ext > bitcnt;
    assign push_ok = bitcnt <= CNT_W'(ACC_W - 32);
    assign mask    = (n == 5'd0) ? '0 : (32'hFFFF_FFFF >> (6'd32 - {1'b0, n}));
    assign field   = acc[31:0] & mask;

    // Next context state and response word for the current command
    always_comb begin
        acc_nx    = acc;
        bitcnt_nx = bitcnt;
        ovf_nx    = ovf;
        unf_nx    = unf;
        bad_nx    = badctx;
        rsp       = '0;
`ifdef CXU_BITBUF_STATS_EN
        cnt_nx    = cons_cnt;
`endif
        case (func)
            F_CLEAR: begin
                acc_nx    = '0;
                bitcnt_nx = '0;
                ovf_nx    = 1'b0;
                unf_nx    = 1'b0;
                bad_nx    = 1'b0;
`ifdef CXU_BITBUF_STATS_EN
                cnt_nx    = '0;
`endif
            end
            F_PUSH: begin
                if (push_ok) begin
                    acc_nx    = acc | (ACC_W'(data) << bitcnt);
                    bitcnt_nx = bitcnt + CNT_W'(32);
                    rsp       = 32'(bitcnt_nx);
                end else begin
                    ovf_nx = 1'b1;
                    rsp    = '1;
                end
            end
            F_PEEK, F_SKIP, F_GET, F_PEEKR: begin
                if (short_n) begin
                    unf_nx = 1'b1;
                end else begin
                    case (func)
                        F_PEEK:  rsp = field;
                        F_PEEKR: rsp = bitrev_n(acc[31:0], n);
                        default: begin
                            acc_nx    = acc >> n;
                            bitcnt_nx = bitcnt - n_ext;
                            rsp       = (func == F_GET) ? field : 32'(bitcnt_nx);
`ifdef CXU_BITBUF_STATS_EN
                            cnt_nx    = cons_cnt + 32'(n);
`endif
                        end
                    endcase
                end
            end
            F_STATUS: rsp = {16'b0, ovf, unf, badctx, 6'b0, ST_CNT_W'(bitcnt)};
            F_STATS: begin
`ifdef CXU_BITBUF_STATS_EN
                rsp = cons_cnt;
`else
                rsp = '0;
`endif
            end
            default: rsp = '0;
        endcase
    end

    // Context state register; BADCTX can also be raised by an illegal-context command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            bitcnt   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            badctx   <= 1'b0;
`ifdef CXU_BITBUF_STATS_EN
            cons_cnt <= '0;
`endif
        end else if (op_en) begin
            acc      <= acc_nx;
            bitcnt   <= bitcnt_nx;
            ovf      <= ovf_nx;
            unf      <= unf_nx;
            badctx   <= bad_nx;
`ifdef CXU_BITBUF_STATS_EN
            cons_cnt <= cnt_nx;
`endif
        end else if (bad_set) begin
            badctx   <= 1'b1;
        end
    end

endmodule

// File: rtl/cxu_bitbuf.sv
// Stateful deflate bit-reader CXU with NUM_CTX independent contexts.
// Decodes commands, routes them to the selected context and registers a
// single response (latency 1, held until rsp_ready).
// Optional feature macro: CXU_BITBUF_STATS_EN (per-context consumed-bit counter).
module cxu_bitbuf import cxu_pkg::*; #(
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned NUM_CTX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    input  logic [2:0]  cmd_payload_state_id,
    input  logic [3:0]  cmd_payload_cxu_id,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int unsigned CNT_W = $clog2(ACC_W + 1);

    logic        fire;
    logic        ctx_legal;
    func_e       func;
    logic [31:0] ctx_rsp [8];
    logic        unused_bits;

    assign cmd_ready   = !rsp_valid | rsp_ready;
    assign fire        = cmd_valid & cmd_ready;
    assign ctx_legal   = 32'(cmd_payload_state_id) < NUM_CTX;
    assign func        = func_e'(cmd_payload_function_id);
    assign unused_bits = ^{cmd_payload_cxu_id, cmd_payload_inputs_1[31:5]};

    // Context slots above NUM_CTX are tied off so the response mux stays 8-wide
    for (genvar g = 0; g < 8; g++) begin : g_ctx
        if (g < NUM_CTX) begin : g_on
            cxu_bitbuf_ctx #(
                .ACC_W(ACC_W),
                .CNT_W(CNT_W)
            ) u_ctx (
                .clk    (clk),
                .reset  (reset),
                .op_en  (fire && ctx_legal && (cmd_payload_state_id == 3'(g))),
                .bad_set((g == 0) && fire && !ctx_legal),
                .func   (func),
                .data   (cmd_payload_inputs_0),
                .n      (cmd_payload_inputs_1[4:0]),
                .rsp    (ctx_rsp[g])
            );
        end else begin : g_off
            assign ctx_rsp[g] = '0;
        end
    end

    // Single response slot: load on accept, drop when consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
        end else if (fire) begin
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= ctx_legal ? ctx_rsp[cmd_payload_state_id] : '0;
        end else if (rsp_ready) begin
            rsp_valid             <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cxu_bitbuf.sv
// Self-checking bench for cxu_bitbuf: directed steps plus random commands,
// checked against a bit-queue reference model of each context.
module tb_cxu_bitbuf;
    import cxu_pkg::*;

    localparam int unsigned NCTX = 4;
    localparam int unsigned ACCW = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic [2:0]  cmd_payload_state_id = '0;
    logic [3:0]  cmd_payload_cxu_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_payload_outputs_0;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    // Reference model: each context is a FIFO of bits, oldest bit first
    bit          mq [NCTX][$];
    bit          m_ovf [NCTX];
    bit          m_unf [NCTX];
    bit          m_bad [NCTX];
    int unsigned m_stats [NCTX];

    cxu_bitbuf #(.ACC_W(ACCW), .NUM_CTX(NCTX)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0   (cmd_payload_inputs_0),
        .cmd_payload_inputs_1   (cmd_payload_inputs_1),
        .cmd_payload_state_id   (cmd_payload_state_id),
        .cmd_payload_cxu_id     (cmd_payload_cxu_id),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_payload_outputs_0  (rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCTX; c++) begin
            mq[c].delete();
            m_ovf[c] = 0;
            m_unf[c] = 0;
            m_bad[c] = 0;
            m_stats[c] = 0;
        end
    endtask

    task automatic model(input int f, input logic [31:0] in0, input int n, input int sid,
                         output logic [31:0] exp);
        exp = '0;
        if (sid >= NCTX) begin
            m_bad[0] = 1;
            return;
        end
        case (f)
            0: begin
                mq[sid].delete();
                m_ovf[sid] = 0;
                m_unf[sid] = 0;
                m_bad[sid] = 0;
                m_stats[sid] = 0;
            end
            1: begin
                if (mq[sid].size() + 32 <= ACCW) begin
                    for (int i = 0; i < 32; i++) mq[sid].push_back(in0[i]);
                    exp = mq[sid].size();
                end else begin
                    m_ovf[sid] = 1;
                    exp = 32'hFFFF_FFFF;
                end
            end
            2, 3, 4, 5: begin
                if (n > mq[sid].size()) begin
                    m_unf[sid] = 1;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        if (f == 5) exp[n-1-i] = mq[sid][i];
                        else        exp[i]     = mq[sid][i];
                    end
                    if (f == 3 || f == 4) begin
                        for (int i = 0; i < n; i++) void'(mq[sid].pop_front());
                        m_stats[sid] += n;
                        if (f == 3) exp = mq[sid].size();
                    end
                end
            end
            6: exp = (32'(m_ovf[sid]) << 15) | (32'(m_unf[sid]) << 14) |
                     (32'(m_bad[sid]) << 13) | 32'(mq[sid].size());
            default: begin
`ifdef CXU_BITBUF_STATS_EN
                exp = m_stats[sid];
`else
                exp = '0;
`endif
            end
        endcase
    endtask

    // Drive one command, wait (bounded) for acceptance, then check the response
    task automatic run(input int f, input logic [31:0] in0, input int n, input int sid,
                       input string tag, output logic [31:0] exp);
        int cyc;
        exp = '0;
        @(negedge clk);
        cmd_payload_function_id = 3'(f);
        cmd_payload_inputs_0    = in0;
        cmd_payload_inputs_1    = 32'(n) | ($urandom & 32'hFFFF_FFE0);
        cmd_payload_state_id    = 3'(sid);
        cmd_payload_cxu_id      = 4'($urandom);
        cmd_valid               = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/ready"}, 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        model(f, in0, n, sid, exp);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/data"}, rsp_payload_outputs_0, exp);
    endtask

    initial begin
        logic [31:0] e, held;
        int f, sid, n, r;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst/valid", 32'(rsp_valid), 32'd0);
        check("rst/data", rsp_payload_outputs_0, 32'd0);
        check("rst/ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle/valid", 32'(rsp_valid), 32'd0);

        run(F_STATUS, 0, 0, 0, "status0", e);
        check("status0/const", rsp_payload_outputs_0, 32'd0);

        // Basic push / get / peek on context 1
        run(F_PUSH, 32'hA5A5_0F0F, 0, 1, "push1", e);
        run(F_GET, 0, 8, 1, "get8", e);
        check("get8/const", rsp_payload_outputs_0, 32'h0000_000F);
        run(F_PEEK, 0, 4, 1, "peek4", e);
        check("peek4/const", rsp_payload_outputs_0, 32'h0000_000F);
        run(F_PEEK, 0, 0, 1, "peek0", e);
        run(F_STATUS, 0, 0, 1, "status1", e);
        check("status1/const", rsp_payload_outputs_0, 32'd24);

        // Fill to ACC_W exactly, then overflow
        run(F_CLEAR, 0, 0, 2, "clr2", e);
        run(F_PUSH, 32'h1111_2222, 0, 2, "fillA", e);
        run(F_PUSH, 32'h3333_4444, 0, 2, "fillB", e);
        check("fillB/const", rsp_payload_outputs_0, 32'd64);
        run(F_PUSH, 32'h5555_6666, 0, 2, "ovf", e);
        check("ovf/const", rsp_payload_outputs_0, 32'hFFFF_FFFF);
        run(F_STATUS, 0, 0, 2, "status2", e);
        check("status2/const", rsp_payload_outputs_0, 32'h0000_8040);
        run(F_GET, 0, 31, 2, "get31", e);

        // Reversed peek and underflow on context 3
        run(F_CLEAR, 0, 0, 3, "clr3", e);
        run(F_PUSH, 32'hC000_0000, 0, 3, "push3", e);
        run(F_SKIP, 0, 29, 3, "skip29", e);
        run(F_PEEKR, 0, 3, 3, "peekr3", e);
        check("peekr3/const", rsp_payload_outputs_0, 32'd3);
        run(F_GET, 0, 5, 3, "unf", e);
        run(F_STATUS, 0, 0, 3, "status3", e);
        check("status3/const", rsp_payload_outputs_0, 32'h0000_4003);

        // Backpressure: response held, command stalled, executed once
        @(posedge clk);
        #1;
        check("drain/valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        run(F_PUSH, 32'h1234_5678, 0, 1, "bp_push", held);
        @(negedge clk);
        cmd_payload_function_id = 3'(F_GET);
        cmd_payload_inputs_1    = 32'd4;
        cmd_payload_state_id    = 3'd1;
        cmd_valid               = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp/ready", 32'(cmd_ready), 32'd0);
            check("bp/valid", 32'(rsp_valid), 32'd1);
            check("bp/stable", rsp_payload_outputs_0, held);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        model(F_GET, 0, 4, 1, e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_get/valid", 32'(rsp_valid), 32'd1);
        check("bp_get/data", rsp_payload_outputs_0, e);
        run(F_STATUS, 0, 0, 1, "bp_status", e);
        check("bp_status/const", rsp_payload_outputs_0, 32'd52);

        // Consumed-bit statistics (zero when the feature is absent)
        run(F_CLEAR, 0, 0, 0, "clr0", e);
        run(F_PUSH, 32'hDEAD_BEEF, 0, 0, "st_push", e);
        run(F_GET, 0, 8, 0, "st_get", e);
        run(F_SKIP, 0, 5, 0, "st_skip", e);
        run(F_STATS, 0, 0, 0, "stats13", e);
        run(F_CLEAR, 0, 0, 0, "st_clr", e);
        run(F_STATS, 0, 0, 0, "stats0", e);

        // Illegal context: no state change, BADCTX in context 0
        run(F_CLEAR, 0, 0, 5, "bad_clr", e);
        run(F_GET, 0, 3, 6, "bad_get", e);
        run(F_STATUS, 0, 0, 0, "bad_status", e);
        check("bad_status/const", rsp_payload_outputs_0, 32'h0000_2000);
        run(F_STATUS, 0, 0, 1, "bad_keep1", e);

        // Random commands
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      f = 1;
            else if (r < 38) f = 0;
            else             f = $urandom_range(2, 7);
            sid = ($urandom_range(0, 9) < 9) ? $urandom_range(0, NCTX - 1) : $urandom_range(NCTX, 7);
            n = $urandom_range(0, 31);
            run(f, $urandom, n, sid, "rnd", e);
        end
        for (int c = 0; c < NCTX; c++) run(F_STATUS, 0, 0, c, "rnd_status", e);

        // Reset while a response is pending drops it
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        run(F_PUSH, 32'hCAFE_F00D, 0, 1, "mid_push", e);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst/valid", 32'(rsp_valid), 32'd0);
        check("midrst/data", rsp_payload_outputs_0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1;
        run(F_STATUS, 0, 0, 1, "post_rst", e);
        check("post_rst/const", rsp_payload_outputs_0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
